// File: rtl/uart_rx_deframer_pkg.sv
// Shared definitions for the UART receive deframer: FSM encodings,
// frame constants and the oversample divisor calculation.
package uart_rx_deframer_pkg;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rxState_t;

    localparam int   RX_DATA_BITS  = 8;
    localparam logic RX_IDLE_LEVEL = 1'b1;

    // Rounded clock divisor for one oversample tick.
    function automatic int calcDiv(input int clkFreq, input int baud, input int overSample);
        return (clkFreq + baud * overSample / 2) / (baud * overSample);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Free-running oversample tick generator: one-clk pulse every DIV clocks.
module uart_rx_tick_gen
    import uart_rx_deframer_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = calcDiv(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Counter wraps at DIV-1 and emits the tick on the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rxData, deframes 8N1 bytes (8E1 when
// UART_RX_PARITY_EN is defined), LSB first, into a one-entry valid/ready
// register, and pulses frameErr / overrun / parityErr for one clk.
module uart_rx_deframer
    import uart_rx_deframer_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxData,
    output logic [7:0] rxByte,
    output logic       rxValid,
    input  logic       rxReady,
    output logic       frameErr,
    output logic       overrun,
    output logic       parityErr,
    output logic       busy
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam logic [SC_W-1:0] SC_HALF  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_FULL  = SC_W'(OVERSAMPLE - 1);
    localparam logic [2:0]      BIT_LAST = 3'(RX_DATA_BITS - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync;
    logic [SYNC_STAGES-1:0] syncVld;
    logic                   s;
    logic                   lineHigh;
    logic                   fall;
    rxState_t               state, stateNext;
    logic [SC_W-1:0]        sc;
    logic [2:0]             bitCnt;
    logic [7:0]             shiftReg;
    logic                   scWrap;
    logic                   sampleTick;
    logic                   stopSample;
    logic                   goodByte;
    logic                   frameBad;
`ifdef UART_RX_PARITY_EN
    logic                   parSample;
    logic                   parBad;
`endif

    uart_rx_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Synchroniser plus a fill marker so the reset value of the chain is
    // never mistaken for a real high-to-low transition.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync     <= {SYNC_STAGES{RX_IDLE_LEVEL}};
            syncVld  <= '0;
            lineHigh <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], rxData};
            syncVld <= {syncVld[SYNC_STAGES-2:0], 1'b1};
            if (syncVld[SYNC_STAGES-1])
                lineHigh <= s;
        end
    end

    assign s          = sync[SYNC_STAGES-1];
    assign fall       = lineHigh && !s;
    assign sampleTick = tick && scWrap;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RX_IDLE;
        else      state <= stateNext;
    end

    // Next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            RX_IDLE:      if (fall) stateNext = RX_START;
            RX_START:     if (sampleTick) stateNext = s ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (sampleTick && bitCnt == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                    stateNext = RX_PARITY;
`else
                    stateNext = RX_STOP;
`endif
            end
            RX_PARITY:    if (sampleTick) stateNext = RX_STOP;
            RX_STOP:      if (sampleTick) stateNext = s ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (s) stateNext = RX_IDLE;
            default:      stateNext = RX_IDLE;
        endcase
    end

    // Output/strobe decode: sample point and frame verdicts.
    always_comb begin
        busy       = (state != RX_IDLE);
        scWrap     = (state == RX_START) ? (sc == SC_HALF) : (sc == SC_FULL);
        stopSample = (state == RX_STOP) && tick && scWrap;
        frameBad   = stopSample && !s;
`ifdef UART_RX_PARITY_EN
        parSample  = (state == RX_PARITY) && tick && scWrap;
        goodByte   = stopSample && s && !parBad;
`else
        goodByte   = stopSample && s;
`endif
    end

    // Sample counter, bit counter and data shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc       <= '0;
            bitCnt   <= '0;
            shiftReg <= '0;
`ifdef UART_RX_PARITY_EN
            parBad   <= 1'b0;
`endif
        end else begin
            if (state == RX_IDLE || state == RX_WAIT_HIGH)
                sc <= '0;
            else if (tick)
                sc <= scWrap ? '0 : sc + 1'b1;

            if (state == RX_IDLE)
                bitCnt <= '0;
            else if (state == RX_DATA && sampleTick) begin
                shiftReg <= {s, shiftReg[7:1]};
                bitCnt   <= bitCnt + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data ones plus parity bit must be even.
            if (state == RX_IDLE)
                parBad <= 1'b0;
            else if (parSample)
                parBad <= ^{shiftReg, s};
`endif
        end
    end

    // One-entry output register and single-cycle error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxByte    <= '0;
            rxValid   <= 1'b0;
            frameErr  <= 1'b0;
            overrun   <= 1'b0;
            parityErr <= 1'b0;
        end else begin
            overrun  <= 1'b0;
            frameErr <= frameBad;
`ifdef UART_RX_PARITY_EN
            parityErr <= parSample && (^{shiftReg, s});
`else
            parityErr <= 1'b0;
`endif
            if (goodByte) begin
                if (!rxValid || rxReady) begin
                    rxByte  <= shiftReg;
                    rxValid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rxValid && rxReady) begin
                rxValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer. The clock is scaled so one bit
// is 64 clocks (DIV=4, OVERSAMPLE=16) to keep runs short.
module tb_uart_rx_deframer;

    localparam int CLK_FREQ = 614400;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int BIT      = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxData;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       rxReady;
    logic       frameErr;
    logic       overrun;
    logic       parityErr;
    logic       busy;

    int nChecks = 0;
    int nErrors = 0;
    logic [7:0] expQ[$];
    int  feCnt, ovCnt, peCnt, peTotal, deliverCnt;
    bit  autoAck;
    int  ackReq, ackDone;
    bit  busySeen;

    typedef struct {
        logic [7:0] data;
        logic       stopLvl;
        logic       expDeliver;
        int         expFe;
    } vec_t;
    vec_t tbl[6];

    uart_rx_deframer #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxData   (rxData),
        .rxByte   (rxByte),
        .rxValid  (rxValid),
        .rxReady  (rxReady),
        .frameErr (frameErr),
        .overrun  (overrun),
        .parityErr(parityErr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clearCounts();
        feCnt = 0; ovCnt = 0; peCnt = 0; deliverCnt = 0;
    endtask

    task automatic sendBits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxData = bits[i];
            repeat (BIT) @(negedge clk);
        end
        rxData = 1'b1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopLvl);
`ifdef UART_RX_PARITY_EN
        sendBits({1'b1, stopLvl, ^d, d, 1'b0}, 11);
`else
        sendBits({2'b11, stopLvl, d, 1'b0}, 10);
`endif
    endtask

    task automatic idleBits(input int n);
        rxData = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    // Monitor / consumer: detects deliveries, checks them against the
    // scoreboard, counts error pulses and drives rxReady.
    initial begin
        logic pv, pacc, pfe, pov, ppe;
        logic [7:0] e;
        pv = 0; pacc = 0; pfe = 0; pov = 0; ppe = 0;
        rxReady = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 0; pacc = 0; pfe = 0; pov = 0; ppe = 0;
                rxReady = 1'b0;
            end else begin
                if (rxValid && (!pv || pacc)) begin
                    deliverCnt++;
                    if (expQ.size() == 0) begin
                        nChecks++; nErrors++;
                        $display("FAIL rxByte unexpected delivery: got %02h, none expected", rxByte);
                    end else begin
                        e = expQ.pop_front();
                        chk("rxByte delivered", {24'd0, rxByte}, {24'd0, e});
                    end
                end
                if (frameErr)  begin feCnt++; chk("frameErr width", {31'd0, pfe}, 0); end
                if (overrun)   begin ovCnt++; chk("overrun width", {31'd0, pov}, 0); end
                if (parityErr) begin peCnt++; peTotal++; chk("parityErr width", {31'd0, ppe}, 0); end
                if (busy) busySeen = 1;
                rxReady = rxValid && !rxReady && (autoAck || ackDone < ackReq);
                if (rxReady && !autoAck) ackDone++;
                pacc = rxValid && rxReady;
                pv = rxValid; pfe = frameErr; pov = overrun; ppe = parityErr;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rxData = 1'b1; autoAck = 0; ackReq = 0; ackDone = 0;
        peTotal = 0; busySeen = 0;
        clearCounts();

        tbl[0] = '{8'h00, 1'b1, 1'b1, 0};
        tbl[1] = '{8'hFF, 1'b1, 1'b1, 0};
        tbl[2] = '{8'h80, 1'b1, 1'b1, 0};
        tbl[3] = '{8'h01, 1'b1, 1'b1, 0};
        tbl[4] = '{8'h3C, 1'b0, 1'b0, 1};
        tbl[5] = '{8'hC3, 1'b1, 1'b1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset rxValid",   {31'd0, rxValid}, 0);
        chk("reset rxByte",    {24'd0, rxByte}, 0);
        chk("reset frameErr",  {31'd0, frameErr}, 0);
        chk("reset overrun",   {31'd0, overrun}, 0);
        chk("reset parityErr", {31'd0, parityErr}, 0);
        chk("reset busy",      {31'd0, busy}, 0);
        rst = 1'b1;
        idleBits(2);

        // 'A' with rxReady low: held in the register
        clearCounts();
        expQ.push_back(8'h41);
        sendFrame(8'h41, 1'b1);
        idleBits(1);
        chk("A rxValid", {31'd0, rxValid}, 1);
        chk("A rxByte", {24'd0, rxByte}, 32'h41);
        chk("A deliveries", deliverCnt, 1);
        chk("A error pulses", feCnt + ovCnt + peCnt, 0);
        ackReq++;
        repeat (4) @(negedge clk);
        chk("A consumed", {31'd0, rxValid}, 0);

        // Back-to-back 55, AA with immediate consumption
        clearCounts();
        autoAck = 1;
        expQ.push_back(8'h55); expQ.push_back(8'hAA);
        sendFrame(8'h55, 1'b1);
        sendFrame(8'hAA, 1'b1);
        idleBits(1);
        chk("b2b deliveries", deliverCnt, 2);
        chk("b2b rxValid", {31'd0, rxValid}, 0);
        chk("b2b overrun", ovCnt, 0);
        autoAck = 0;

        // Overrun: 46 held, 52 dropped
        clearCounts();
        expQ.push_back(8'h46);
        sendFrame(8'h46, 1'b1);
        sendFrame(8'h52, 1'b1);
        idleBits(1);
        chk("ovr pulses", ovCnt, 1);
        chk("ovr rxValid", {31'd0, rxValid}, 1);
        chk("ovr rxByte kept", {24'd0, rxByte}, 32'h46);
        chk("ovr deliveries", deliverCnt, 1);
        ackReq++;
        repeat (4) @(negedge clk);
        chk("ovr consumed", {31'd0, rxValid}, 0);

        // Table of data patterns, including a bad stop bit
        autoAck = 1;
        for (int i = 0; i < 6; i++) begin
            clearCounts();
            if (tbl[i].expDeliver) expQ.push_back(tbl[i].data);
            sendFrame(tbl[i].data, tbl[i].stopLvl);
            idleBits(2);
            chk("tbl deliveries", deliverCnt, {31'd0, tbl[i].expDeliver});
            chk("tbl frameErr", feCnt, tbl[i].expFe);
            chk("tbl overrun", ovCnt, 0);
        end
        autoAck = 0;

        // Framing error followed by a 3-bit break
        clearCounts();
        sendFrame(8'h53, 1'b0);
        rxData = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        chk("brk frameErr", feCnt, 1);
        chk("brk rxValid", {31'd0, rxValid}, 0);
        chk("brk busy in wait", {31'd0, busy}, 1);
        idleBits(1);
        chk("brk busy released", {31'd0, busy}, 0);
        expQ.push_back(8'h4C);
        sendFrame(8'h4C, 1'b1);
        idleBits(1);
        chk("brk next rxByte", {24'd0, rxByte}, 32'h4C);
        chk("brk next deliveries", deliverCnt, 1);
        chk("brk extra frameErr", feCnt, 1);
        ackReq++;
        repeat (4) @(negedge clk);

        // 0.3-bit glitch: false start
        clearCounts();
        busySeen = 0;
        rxData = 1'b0;
        repeat (19) @(negedge clk);
        rxData = 1'b1;
        for (int k = 0; k < 4 * BIT && busy; k++) @(negedge clk);
        chk("glitch busy seen", {31'd0, busySeen}, 1);
        chk("glitch busy cleared", {31'd0, busy}, 0);
        chk("glitch rxValid", {31'd0, rxValid}, 0);
        chk("glitch pulses", feCnt + ovCnt + peCnt + deliverCnt, 0);

        // Reset mid-frame with a byte held
        clearCounts();
        expQ.push_back(8'h33);
        sendFrame(8'h33, 1'b1);
        idleBits(1);
        chk("rst held byte", {31'd0, rxValid}, 1);
        sendBits(12'b1111_1111_1010, 4);
        rxData = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst rxValid", {31'd0, rxValid}, 0);
        chk("rst rxByte", {24'd0, rxByte}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst pulses", {29'd0, frameErr, overrun, parityErr}, 0);
        rxData = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        idleBits(2);
        clearCounts();
        expQ.push_back(8'h4C);
        sendFrame(8'h4C, 1'b1);
        idleBits(1);
        chk("post-rst rxByte", {24'd0, rxByte}, 32'h4C);
        chk("post-rst deliveries", deliverCnt, 1);
        ackReq++;
        repeat (4) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // 07 with correct (1) and wrong (0) parity
        clearCounts();
        expQ.push_back(8'h07);
        sendBits({1'b1, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
        idleBits(1);
        chk("par good deliveries", deliverCnt, 1);
        chk("par good parityErr", peCnt, 0);
        ackReq++;
        repeat (4) @(negedge clk);
        clearCounts();
        sendBits({1'b1, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
        idleBits(1);
        chk("par bad parityErr", peCnt, 1);
        chk("par bad deliveries", deliverCnt, 0);
        chk("par bad rxValid", {31'd0, rxValid}, 0);
`else
        chk("parityErr never pulsed", peTotal, 0);
`endif

        chk("scoreboard drained", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
